calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
- Top-level control FSM of the keypad calculator.
- Consumes decoded key strobes and sequences digit entry into operand A and operand B; each operand block takes a load strobe, a digit and a digit index.
- Latches the selected operator, starts the ALU through a start/done handshake, and selects what the display shows.
- Handles clear, overflow error and ALU timeout.

Parameters:
- MAX_DIGITS, 4, digits accepted per operand (1..4); extra digits are ignored.
- ALU_TIMEOUT, 255, cycles to wait for alu_done before entering ERROR (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- key_valid  in  1  one-cycle key strobe.
- key_code  in  4  0-9 digit, 10 '+', 11 '-', 12 '*', 13 '=', 14 'C', 15 reserved.
- key_ready  out  1  high when a non-C key can be accepted.
- load_a  out  1  one-cycle load strobe to operand A.
- load_b  out  1  one-cycle load strobe to operand B.
- clr_a  out  1  one-cycle clear to operand A.
- clr_b  out  1  one-cycle clear to operand B.
- digit_out  out  4  digit that accompanies load_a/load_b.
- digit_idx  out  2  position of that digit, 0 = first.
- alu_start  out  1  one-cycle ALU start pulse.
- alu_op  out  2  0 add, 1 sub, 2 mul; held stable from alu_start to completion.
- alu_done  in  1  ALU result valid, one cycle.
- alu_ovf  in  1  overflow flag, sampled with alu_done.
- disp_sel  out  2  0 operand A, 1 operand B, 2 result, 3 error.
- busy  out  1  high in EXEC.

Behaviour:
- Reset (rst low, asynchronous): state = IDLE; key_ready = 1; all other outputs = 0; digit counter = 0; timeout counter = 0.
- Accepted key: key_valid && (key_ready || key_code == 14).
  - Code 15 is ignored everywhere.
  - Keys not accepted are dropped, not queued.
- All outputs are registered. A key accepted in cycle N produces its strobes in cycle N+1.
- States: IDLE, CLR_A, ENTER_A, OP_SEL, CLR_B, ENTER_B, EXEC, RESULT, ERROR.
- First digit of an operand (digit in IDLE/RESULT for A, digit in OP_SEL for B):
  - The digit is buffered.
  - Cycle N+1: clr_x pulses and the state is CLR_x, with key_ready = 0.
  - Cycle N+2: load_x pulses with digit_idx = 0, the state becomes ENTER_x, and key_ready returns to 1.
- Digit in ENTER_x: load_x pulses with digit_idx = counter, then the counter increments. Once counter == MAX_DIGITS, further digits are ignored with no strobe.
- ENTER_A, operator key: latch alu_op, go to OP_SEL.
- OP_SEL, operator key: replaces the latched alu_op and stays in OP_SEL.
- Operator keys in IDLE or RESULT are ignored.
- ENTER_B, '=': go to EXEC.
  - alu_start pulses in the first EXEC cycle; key_ready = 0; busy = 1.
  - The timeout counter starts at 0 and increments every EXEC cycle.
- EXEC exit:
  - alu_done && !alu_ovf: go to RESULT.
  - alu_done && alu_ovf: go to ERROR.
  - Counter reaches ALU_TIMEOUT without alu_done: go to ERROR.
- '=' outside ENTER_B is ignored.
- 'C' in any state: clr_a and clr_b pulse together; alu_op = 0; counters = 0; state = IDLE.
  - 'C' in EXEC aborts the operation; a later alu_done is ignored.
  - 'C' in the same cycle as alu_done: 'C' wins and the result is discarded.
- ERROR: key_ready = 0; only 'C' exits.
- RESULT: a digit starts a new A entry (CLR_A path). Operator and '=' are ignored.
- disp_sel by state:
  - IDLE/CLR_A/ENTER_A/OP_SEL: 0.
  - CLR_B/ENTER_B/EXEC: 1.
  - RESULT: 2.
  - ERROR: 3.
- Widths: digit counter and timeout counter saturate and never wrap. digit_idx is the low 2 bits of the digit counter.
- Reset asserted mid-operation returns to the reset values immediately, with no pulses.

Test Plan:
- Keys 1,2,3,'+',4,5,'=' with alu_done 3 cycles after alu_start:
  - clr_a, then load_a digit 1/idx 0, digit 2/idx 1, digit 3/idx 2.
  - alu_op = 0; clr_b, then load_b 4/idx 0, 5/idx 1.
  - One alu_start pulse; busy for 4 cycles; disp_sel ends at 2.
- Keys 9,9,9,9,7: four load_a strobes at idx 0-3; the fifth digit produces no strobe; state stays ENTER_A.
- Keys 5,'+','*',6,'=': alu_op = 2 at alu_start; only one clr_b.
- Key '=' followed by alu_done with alu_ovf = 1:
  - disp_sel = 3 and key_ready = 0.
  - Digit 3 and '=' are ignored.
  - 'C' gives clr_a/clr_b pulses, IDLE, disp_sel = 0.
- No alu_done with ALU_TIMEOUT = 8: ERROR is entered 8 cycles after alu_start.
- 'C' in the same cycle as alu_done (alu_ovf = 0): IDLE, disp_sel = 0, never RESULT.
- rst low during CLR_A: load_a is never pulsed; all outputs are at reset values.

Source files
------------

// File: rtl/calc_sequencer.sv
// Keypad calculator control FSM: sequences operand digit entry, operator latch,
// ALU start/done handshake, display selection, clear, overflow and ALU timeout.
module calc_sequencer #(
  parameter int MAX_DIGITS  = 4,
  parameter int ALU_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic       load_a,
  output logic       load_b,
  output logic       clr_a,
  output logic       clr_b,
  output logic [3:0] digit_out,
  output logic [1:0] digit_idx,
  output logic       alu_start,
  output logic [1:0] alu_op,
  input  logic       alu_done,
  input  logic       alu_ovf,
  output logic [1:0] disp_sel,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, CLR_A, ENTER_A, OP_SEL, CLR_B, ENTER_B, EXEC, RESULT, ERROR
  } state_t;

  localparam logic [2:0] MAX_D    = 3'(MAX_DIGITS);
  localparam logic [7:0] TMO_LAST = 8'(ALU_TIMEOUT - 1);

  state_t     state, state_d;
  logic [2:0] cnt, cnt_d;
  logic [7:0] tcnt, tcnt_d;
  logic [3:0] dbuf, dbuf_d;
  logic [1:0] op_d, op_code;
  logic [3:0] digit_d;
  logic [1:0] idx_d, disp_d;
  logic       load_a_d, load_b_d, clr_a_d, clr_b_d, start_d, ready_d, busy_d;
  logic       acc, is_digit, is_op, is_eq, is_clr;

  // 'C' bypasses key_ready so it can abort EXEC and leave ERROR.
  assign acc      = key_valid && (key_ready || key_code == 4'd14);
  assign is_digit = acc && (key_code <= 4'd9);
  assign is_op    = acc && (key_code >= 4'd10) && (key_code <= 4'd12);
  assign is_eq    = acc && (key_code == 4'd13);
  assign is_clr   = acc && (key_code == 4'd14);

  always_comb begin
    case (key_code)
      4'd11:   op_code = 2'd1;
      4'd12:   op_code = 2'd2;
      default: op_code = 2'd0;
    endcase
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    tcnt_d   = tcnt;
    dbuf_d   = dbuf;
    op_d     = alu_op;
    digit_d  = digit_out;
    idx_d    = digit_idx;
    load_a_d = 1'b0;
    load_b_d = 1'b0;
    clr_a_d  = 1'b0;
    clr_b_d  = 1'b0;
    start_d  = 1'b0;
    if (is_clr) begin
      state_d = IDLE;
      clr_a_d = 1'b1;
      clr_b_d = 1'b1;
      op_d    = 2'd0;
      cnt_d   = 3'd0;
      tcnt_d  = 8'd0;
    end else begin
      case (state)
        IDLE, RESULT: begin
          if (is_digit) begin
            dbuf_d  = key_code;
            clr_a_d = 1'b1;
            state_d = CLR_A;
          end
        end
        CLR_A: begin
          load_a_d = 1'b1;
          digit_d  = dbuf;
          idx_d    = 2'd0;
          cnt_d    = 3'd1;
          state_d  = ENTER_A;
        end
        ENTER_A: begin
          if (is_digit && cnt < MAX_D) begin
            load_a_d = 1'b1;
            digit_d  = key_code;
            idx_d    = cnt[1:0];
            cnt_d    = cnt + 3'd1;
          end else if (is_op) begin
            op_d    = op_code;
            state_d = OP_SEL;
          end
        end
        OP_SEL: begin
          if (is_op) begin
            op_d = op_code;
          end else if (is_digit) begin
            dbuf_d  = key_code;
            clr_b_d = 1'b1;
            state_d = CLR_B;
          end
        end
        CLR_B: begin
          load_b_d = 1'b1;
          digit_d  = dbuf;
          idx_d    = 2'd0;
          cnt_d    = 3'd1;
          state_d  = ENTER_B;
        end
        ENTER_B: begin
          if (is_digit && cnt < MAX_D) begin
            load_b_d = 1'b1;
            digit_d  = key_code;
            idx_d    = cnt[1:0];
            cnt_d    = cnt + 3'd1;
          end else if (is_eq) begin
            start_d = 1'b1;
            tcnt_d  = 8'd0;
            state_d = EXEC;
          end
        end
        EXEC: begin
          if (tcnt != 8'hFF) tcnt_d = tcnt + 8'd1;
          if (alu_done)              state_d = alu_ovf ? ERROR : RESULT;
          else if (tcnt >= TMO_LAST) state_d = ERROR;
        end
        ERROR:   state_d = ERROR;
        default: state_d = IDLE;
      endcase
    end

    // Status outputs are registered, so derive them from the next state.
    ready_d = 1'b0;
    disp_d  = 2'd0;
    busy_d  = 1'b0;
    case (state_d)
      IDLE, ENTER_A, OP_SEL: ready_d = 1'b1;
      CLR_B:   disp_d = 2'd1;
      ENTER_B: begin ready_d = 1'b1; disp_d = 2'd1; end
      EXEC:    begin busy_d = 1'b1; disp_d = 2'd1; end
      RESULT:  begin ready_d = 1'b1; disp_d = 2'd2; end
      ERROR:   disp_d = 2'd3;
      default: ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      tcnt      <= 8'd0;
      dbuf      <= 4'd0;
      key_ready <= 1'b1;
      load_a    <= 1'b0;
      load_b    <= 1'b0;
      clr_a     <= 1'b0;
      clr_b     <= 1'b0;
      digit_out <= 4'd0;
      digit_idx <= 2'd0;
      alu_start <= 1'b0;
      alu_op    <= 2'd0;
      disp_sel  <= 2'd0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      tcnt      <= tcnt_d;
      dbuf      <= dbuf_d;
      key_ready <= ready_d;
      load_a    <= load_a_d;
      load_b    <= load_b_d;
      clr_a     <= clr_a_d;
      clr_b     <= clr_b_d;
      digit_out <= digit_d;
      digit_idx <= idx_d;
      alu_start <= start_d;
      alu_op    <= op_d;
      disp_sel  <= disp_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: per-cycle state table plus a
// cycle-stamped scoreboard of strobe events, and hand-written corner cases.
module tb_calc_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       alu_done = 1'b0;
  logic       alu_ovf = 1'b0;
  logic       key_ready, load_a, load_b, clr_a, clr_b, alu_start, busy;
  logic [3:0] digit_out;
  logic [1:0] digit_idx, alu_op, disp_sel;

  calc_sequencer #(.MAX_DIGITS(4), .ALU_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .load_a(load_a), .load_b(load_b),
    .clr_a(clr_a), .clr_b(clr_b), .digit_out(digit_out), .digit_idx(digit_idx),
    .alu_start(alu_start), .alu_op(alu_op), .alu_done(alu_done),
    .alu_ovf(alu_ovf), .disp_sel(disp_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam int S_IDLE = 0, S_CLRA = 1, S_ENTA = 2, S_OPS = 3, S_CLRB = 4,
                 S_ENTB = 5, S_EXEC = 6, S_RES = 7, S_ERR = 8;

  typedef struct packed {
    logic       ca, cb, la, lb, st;
    logic [3:0] dig;
    logic [1:0] idx;
    logic [1:0] op;
  } ev_t;

  typedef struct packed {
    int  cyc;
    ev_t ev;
  } sb_t;

  typedef struct {
    logic       rst;
    logic       kv;
    logic [3:0] kc;
    logic       done;
    logic       ovf;
    int         st;
    ev_t        ev;
  } step_t;

  step_t steps[$];
  sb_t   sbq[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    mon_en = 1'b0;

  // {key_ready, disp_sel, busy} expected in each state
  function automatic logic [3:0] exp_out(input int s);
    case (s)
      S_CLRA:  return 4'b0_00_0;
      S_CLRB:  return 4'b0_01_0;
      S_ENTB:  return 4'b1_01_0;
      S_EXEC:  return 4'b0_01_1;
      S_RES:   return 4'b1_10_0;
      S_ERR:   return 4'b0_11_0;
      default: return 4'b1_00_0;
    endcase
  endfunction

  function automatic ev_t e_none();
    return '0;
  endfunction

  function automatic ev_t e_clr(input int a, input int b);
    ev_t e = '0;
    e.ca = (a != 0);
    e.cb = (b != 0);
    return e;
  endfunction

  function automatic ev_t e_ld(input int b, input int d, input int i);
    ev_t e = '0;
    e.la  = (b == 0);
    e.lb  = (b != 0);
    e.dig = 4'(d);
    e.idx = 2'(i);
    return e;
  endfunction

  function automatic ev_t e_st(input int op);
    ev_t e = '0;
    e.st = 1'b1;
    e.op = 2'(op);
    return e;
  endfunction

  function automatic void add(input int r, input int kv, input int kc, input int d,
                              input int o, input int s, input ev_t e);
    step_t x;
    x.rst  = (r != 0);
    x.kv   = (kv != 0);
    x.kc   = 4'(kc);
    x.done = (d != 0);
    x.ovf  = (o != 0);
    x.st   = s;
    x.ev   = e;
    steps.push_back(x);
  endfunction

  function automatic void key(input int kc, input int s, input ev_t e);
    add(1, 1, kc, 0, 0, s, e);
  endfunction

  function automatic void idle(input int s, input ev_t e);
    add(1, 0, 0, 0, 0, s, e);
  endfunction

  always @(posedge clk) cyc++;

  // Strobe monitor: every observed strobe must match the next scoreboard entry,
  // including the cycle it was due in.
  always @(negedge clk) begin
    ev_t o;
    sb_t x;
    if (mon_en) begin
      o = '0;
      o.ca = clr_a; o.cb = clr_b; o.la = load_a; o.lb = load_b; o.st = alu_start;
      if (load_a || load_b) begin o.dig = digit_out; o.idx = digit_idx; end
      if (alu_start) o.op = alu_op;
      if (o != '0) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL strobe_unexpected cyc=%0d actual=%h required=none", cyc, o);
        end else begin
          x = sbq.pop_front();
          if (x.cyc != cyc || x.ev != o) begin
            errors++;
            $display("FAIL strobe cyc=%0d actual=%h required=%h at cyc %0d", cyc, o, x.ev, x.cyc);
          end
        end
      end else if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
        checks++;
        errors++;
        x = sbq.pop_front();
        $display("FAIL strobe_missing cyc=%0d actual=none required=%h", cyc, x.ev);
      end
    end
  end

  task automatic press(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    #1;
    key_valid = 1'b0;
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] got;
    logic [3:0] want;
    logic [19:0] rst_vec;
    sb_t x;
    int n;

    repeat (2) @(negedge clk);
    rst_vec = {key_ready, load_a, load_b, clr_a, clr_b, digit_out, digit_idx,
               alu_start, alu_op, disp_sel, busy, 3'b000};
    checks++;
    if (rst_vec != 20'h80000) begin
      errors++;
      $display("FAIL reset_state actual=%h required=%h", rst_vec, 20'h80000);
    end
    #1;
    rst = 1'b1;

    // Ignored keys in IDLE
    key(15, S_IDLE, e_none()); key(10, S_IDLE, e_none()); key(13, S_IDLE, e_none());
    // 123 + 45 =, done three cycles after start
    key(1, S_CLRA, e_clr(1, 0)); idle(S_ENTA, e_ld(0, 1, 0));
    key(2, S_ENTA, e_ld(0, 2, 1)); key(3, S_ENTA, e_ld(0, 3, 2));
    key(10, S_OPS, e_none()); key(4, S_CLRB, e_clr(0, 1)); idle(S_ENTB, e_ld(1, 4, 0));
    key(5, S_ENTB, e_ld(1, 5, 1)); key(13, S_EXEC, e_st(0));
    idle(S_EXEC, e_none()); idle(S_EXEC, e_none()); idle(S_EXEC, e_none());
    add(1, 0, 0, 1, 0, S_RES, e_none());
    key(10, S_RES, e_none()); key(13, S_RES, e_none());
    // 5 + * 6 = from RESULT, then overflow into ERROR
    key(5, S_CLRA, e_clr(1, 0)); idle(S_ENTA, e_ld(0, 5, 0));
    key(10, S_OPS, e_none()); key(12, S_OPS, e_none());
    key(6, S_CLRB, e_clr(0, 1)); idle(S_ENTB, e_ld(1, 6, 0));
    key(13, S_EXEC, e_st(2)); idle(S_EXEC, e_none());
    add(1, 0, 0, 1, 1, S_ERR, e_none());
    key(3, S_ERR, e_none()); key(13, S_ERR, e_none()); key(14, S_IDLE, e_clr(1, 1));
    // 9999 7: key during CLR_A dropped, fifth digit ignored, then timeout
    key(9, S_CLRA, e_clr(1, 0)); key(5, S_ENTA, e_ld(0, 9, 0));
    key(9, S_ENTA, e_ld(0, 9, 1)); key(9, S_ENTA, e_ld(0, 9, 2)); key(9, S_ENTA, e_ld(0, 9, 3));
    key(7, S_ENTA, e_none()); key(13, S_ENTA, e_none());
    key(11, S_OPS, e_none()); key(2, S_CLRB, e_clr(0, 1)); idle(S_ENTB, e_ld(1, 2, 0));
    key(13, S_EXEC, e_st(1));
    for (int k = 0; k < 7; k++) idle(S_EXEC, e_none());
    idle(S_ERR, e_none());
    add(1, 0, 0, 1, 0, S_ERR, e_none());
    key(14, S_IDLE, e_clr(1, 1));
    // 'C' in the same cycle as alu_done, then a stale alu_done
    key(1, S_CLRA, e_clr(1, 0)); idle(S_ENTA, e_ld(0, 1, 0));
    key(10, S_OPS, e_none()); key(1, S_CLRB, e_clr(0, 1)); idle(S_ENTB, e_ld(1, 1, 0));
    key(13, S_EXEC, e_st(0)); idle(S_EXEC, e_none());
    add(1, 1, 14, 1, 0, S_IDLE, e_clr(1, 1));
    idle(S_IDLE, e_none());
    add(1, 0, 0, 1, 0, S_IDLE, e_none());
    // Reset during CLR_A: no load_a ever follows
    key(4, S_CLRA, e_clr(1, 0));
    add(0, 0, 0, 0, 0, S_IDLE, e_none());
    add(0, 1, 4, 0, 0, S_IDLE, e_none());
    idle(S_IDLE, e_none());
    idle(S_IDLE, e_none());

    mon_en = 1'b1;
    for (int i = 0; i < steps.size(); i++) begin
      rst       = steps[i].rst;
      key_valid = steps[i].kv;
      key_code  = steps[i].kc;
      alu_done  = steps[i].done;
      alu_ovf   = steps[i].ovf;
      if (steps[i].ev != '0) begin
        x.cyc = cyc + 1;
        x.ev  = steps[i].ev;
        sbq.push_back(x);
      end
      @(negedge clk);
      got  = {key_ready, disp_sel, busy};
      want = exp_out(steps[i].st);
      checks++;
      if (got != want) begin
        errors++;
        $display("FAIL step%0d ready_disp_busy actual=%b required=%b", i, got, want);
      end
      #1;
    end
    rst = 1'b1;
    key_valid = 1'b0;
    alu_done = 1'b0;
    alu_ovf = 1'b0;
    @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sbq.size());
    end
    mon_en = 1'b0;
    #1;

    // 'C' clears a latched multiply
    press(4'd1); press(4'd12); press(4'd2);
    key_valid = 1'b1;
    key_code  = 4'd14;
    @(negedge clk);
    checks++;
    if (alu_op != 2'd0 || disp_sel != 2'd0 || !clr_a || !clr_b) begin
      errors++;
      $display("FAIL clear_op actual=op%0d disp%0d clr%b%b required=op0 disp0 clr11",
               alu_op, disp_sel, clr_a, clr_b);
    end
    #1;
    key_valid = 1'b0;

    // Timeout: ERROR exactly ALU_TIMEOUT cycles after alu_start
    press(4'd1); press(4'd11); press(4'd2);
    key_valid = 1'b1;
    key_code  = 4'd13;
    @(negedge clk);
    checks++;
    if (!alu_start || alu_op != 2'd1) begin
      errors++;
      $display("FAIL timeout_start actual=start%b op%0d required=start1 op1", alu_start, alu_op);
    end
    #1;
    key_valid = 1'b0;
    n = 0;
    while (disp_sel != 2'd3 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL timeout_cycles actual=%0d required=8", n);
    end
    #1;
    press(4'd14);
    checks++;
    if (disp_sel != 2'd0 || !key_ready) begin
      errors++;
      $display("FAIL error_exit actual=disp%0d ready%b required=disp0 ready1", disp_sel, key_ready);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
